// File: rtl/i2c_master_pkg.sv
// Shared constants for the I2C master register map.
// Holds the register indices, CR1/CR2/SR1 bit positions, the version word,
// the number of control registers and the base address of the status bank.
package i2c_master_pkg;

  // Control register indices (word addresses)
  localparam int I2C_CR1_CR   = 0;
  localparam int I2C_CR2_CR   = 1;
  localparam int I2C_OAR1_CR  = 2;
  localparam int I2C_OAR2_CR  = 3;
  localparam int I2C_DR_CR    = 4;
  localparam int I2C_SR1_CR   = 5;
  localparam int I2C_SR2_CR   = 6;
  localparam int I2C_CCR_CR   = 7;
  localparam int I2C_TRISE_CR = 8;
  localparam int I2C_CR_CNT   = 9;

  // Read-only status bank starts right after the control registers
  localparam int I2C_SR_BASE  = I2C_CR_CNT;

  localparam logic [15:0] I2C_VER = 16'h0001;

  // CR1 bit positions
  localparam int I2C_CR1_PE        = 0;
  localparam int I2C_CR1_SMBUS     = 1;
  localparam int I2C_CR1_ENGC      = 6;
  localparam int I2C_CR1_NOSTRETCH = 7;
  localparam int I2C_CR1_START     = 8;
  localparam int I2C_CR1_STOP      = 9;
  localparam int I2C_CR1_ACK       = 10;
  localparam int I2C_CR1_POS       = 11;
  localparam int I2C_CR1_SWRST_EN  = 15;

  // CR2 bit positions
  localparam int I2C_CR2_FREQ_LSB  = 0;
  localparam int I2C_CR2_FREQ_W    = 6;
  localparam int I2C_CR2_ITERREN   = 8;
  localparam int I2C_CR2_ITEVTEN   = 9;
  localparam int I2C_CR2_ITBUFEN   = 10;

  // SR1 flag positions
  localparam int I2C_SR1_SB        = 0;
  localparam int I2C_SR1_ADDR      = 1;
  localparam int I2C_SR1_BTF       = 2;
  localparam int I2C_SR1_RXNE      = 6;
  localparam int I2C_SR1_TXE       = 7;
  localparam int I2C_SR1_AF        = 10;

endpackage

// File: rtl/i2c_w1c_flags.sv
// Sticky event flags with write-1-to-clear.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   set_i          : per-bit set pulses (win over a same-cycle clear)
//   clr_i          : per-bit clear requests
//   clr_all_i      : synchronous clear of every flag (overrides set)
//   flags_o        : current flag state
//   flags_d_o      : flag state that will be loaded on the next edge
module i2c_w1c_flags #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clr_i,
  input  logic             clr_all_i,
  output logic [WIDTH-1:0] flags_o,
  output logic [WIDTH-1:0] flags_d_o
);

  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;

  always_comb begin
    flags_d = (flags_q & ~clr_i) | set_i;
    if (clr_all_i) flags_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign flags_o   = flags_q;
  assign flags_d_o = flags_d;

endmodule

// File: rtl/i2c_master_csr.sv
// Control/status register block for the I2C master.
// Decodes a single-cycle memory-mapped bus into the control registers,
// produces START/STOP self-clearing bits, SR1 sticky W1C flags, DR push/pop
// strobes, the software reset pulse and the interrupt request, and serves
// the read-only version/status bank.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   csr_*                 : slave bus (1-cycle read latency, no wait states)
//   cr_o                  : flattened control registers, reg i at [i*DATA_W +: DATA_W]
//   sr_i                  : engine status for status-bank registers 1..SR_CNT-1
//   sr1_set_i             : event pulses setting SR1 flags
//   sr2_i                 : live engine status, read at the SR2 address
//   tx_data_o, tx_valid_o : byte written to DR and its push strobe
//   rx_data_i, rx_pop_o   : receive byte and pop strobe on DR reads
//   swrst_o               : one-cycle software reset pulse
//   irq_o                 : interrupt request (any SR1 flag while PE set)
module i2c_master_csr
  import i2c_master_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 4,
  parameter int                CR_CNT = I2C_CR_CNT,
  parameter int                SR_CNT = 2,
  parameter logic [DATA_W-1:0] VER    = DATA_W'(I2C_VER)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [ADDR_W-1:0]          csr_address_i,
  input  logic                       csr_write_i,
  input  logic [DATA_W-1:0]          csr_writedata_i,
  input  logic [DATA_W/8-1:0]        csr_byteenable_i,
  input  logic                       csr_read_i,
  output logic [DATA_W-1:0]          csr_readdata_o,
  output logic                       csr_readdatavalid_o,
  output logic [CR_CNT*DATA_W-1:0]   cr_o,
  input  logic [(SR_CNT-1)*DATA_W-1:0] sr_i,
  input  logic [DATA_W-1:0]          sr1_set_i,
  input  logic [DATA_W-1:0]          sr2_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic [7:0]                 rx_data_i,
  output logic                       rx_pop_o,
  output logic                       swrst_o,
  output logic                       irq_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] CR1_SELFCLR =
    (DATA_W'(1) << I2C_CR1_START) | (DATA_W'(1) << I2C_CR1_STOP);

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // DR, SR1 and SR2 have no generic storage behind them
  function automatic logic is_storage_cr(input int idx);
    return !(idx == I2C_DR_CR || idx == I2C_SR1_CR || idx == I2C_SR2_CR);
  endfunction

  // Bus decode
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] wbits;
  logic              cr1_wr;
  logic              sr1_wr;
  logic              dr_wr;
  logic              dr_rd;
  logic              swrst_req;

  assign wmask     = lane_mask(csr_byteenable_i);
  assign wbits     = csr_writedata_i & wmask;
  assign cr1_wr    = csr_write_i && (csr_address_i == ADDR_W'(I2C_CR1_CR));
  assign sr1_wr    = csr_write_i && (csr_address_i == ADDR_W'(I2C_SR1_CR));
  assign dr_wr     = csr_write_i && (csr_address_i == ADDR_W'(I2C_DR_CR)) && csr_byteenable_i[0];
  assign dr_rd     = csr_read_i  && (csr_address_i == ADDR_W'(I2C_DR_CR));
  assign swrst_req = cr1_wr && wbits[I2C_CR1_SWRST_EN];

  // SR1 sticky flags
  logic [DATA_W-1:0] sr1_q;
  logic [DATA_W-1:0] sr1_d;

  i2c_w1c_flags #(
    .WIDTH (DATA_W)
  ) u_sr1 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .set_i     (sr1_set_i),
    .clr_i     (sr1_wr ? wbits : '0),
    .clr_all_i (swrst_req),
    .flags_o   (sr1_q),
    .flags_d_o (sr1_d)
  );

  // Generic control registers
  logic [DATA_W-1:0] cr_q [CR_CNT];
  logic [DATA_W-1:0] cr_d [CR_CNT];

  always_comb begin
    for (int i = 0; i < CR_CNT; i++) begin
      cr_d[i] = cr_q[i];
      // START/STOP live for exactly one cycle after being written
      if (i == I2C_CR1_CR) cr_d[i] = cr_d[i] & ~CR1_SELFCLR;
      if (csr_write_i && (csr_address_i == ADDR_W'(i)))
        cr_d[i] = (cr_d[i] & ~wmask) | wbits;
      if (i == I2C_CR1_CR) cr_d[i][I2C_CR1_SWRST_EN] = 1'b0;
      if (!is_storage_cr(i) || swrst_req) cr_d[i] = '0;
    end
  end

  // Outward view of the register map: SR1 comes from the flag block,
  // DR and SR2 read as zero on cr_o since they carry no stored state.
  logic [DATA_W-1:0] cr_view [CR_CNT];

  always_comb begin
    for (int i = 0; i < CR_CNT; i++)
      cr_view[i] = (i == I2C_SR1_CR) ? sr1_q : cr_q[i];
  end

  for (genvar g = 0; g < CR_CNT; g++) begin : g_cr_o
    assign cr_o[g*DATA_W +: DATA_W] = cr_view[g];
  end

  // Status bank: slot 0 is the version word, the rest come from sr_i
  logic [DATA_W-1:0] sr_bank [SR_CNT];

  assign sr_bank[0] = VER;
  for (genvar k = 1; k < SR_CNT; k++) begin : g_sr_bank
    assign sr_bank[k] = sr_i[(k-1)*DATA_W +: DATA_W];
  end

  // Read mux; unmapped addresses fall through to zero
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < CR_CNT; i++)
      if (csr_address_i == ADDR_W'(i)) rdata_d = cr_view[i];
    if (csr_address_i == ADDR_W'(I2C_DR_CR))  rdata_d = DATA_W'(rx_data_i);
    if (csr_address_i == ADDR_W'(I2C_SR2_CR)) rdata_d = sr2_i;
    for (int k = 0; k < SR_CNT; k++)
      if (csr_address_i == ADDR_W'(CR_CNT + k)) rdata_d = sr_bank[k];
  end

  // Registered outputs
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              rx_pop_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic              swrst_q;
  logic              irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CR_CNT; i++) cr_q[i] <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rx_pop_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      swrst_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < CR_CNT; i++) cr_q[i] <= cr_d[i];
      if (csr_read_i) rdata_q <= rdata_d;
      rvalid_q   <= csr_read_i;
      rx_pop_q   <= dr_rd;
      tx_valid_q <= dr_wr;
      if (dr_wr) tx_data_q <= csr_writedata_i[7:0];
      swrst_q    <= swrst_req;
      // Built from next-state values so irq_o tracks SR1/PE with no extra lag
      irq_q      <= (|sr1_d) & cr_d[I2C_CR1_CR][I2C_CR1_PE];
    end
  end

  assign csr_readdata_o      = rdata_q;
  assign csr_readdatavalid_o = rvalid_q;
  assign rx_pop_o            = rx_pop_q;
  assign tx_valid_o          = tx_valid_q;
  assign tx_data_o           = tx_data_q;
  assign swrst_o             = swrst_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_i2c_master_csr.sv
// Self-checking bench for i2c_master_csr: directed register-map scenarios
// followed by randomized bus traffic compared against a behavioural model.
module tb_i2c_master_csr;
  import i2c_master_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int CRN = 9;
  localparam int SRN = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [AW-1:0]        addr = '0;
  logic                 wr = 1'b0;
  logic                 rd = 1'b0;
  logic [DW-1:0]        wdata = '0;
  logic [1:0]           be = '0;
  logic [DW-1:0]        rdata;
  logic                 rvalid;
  logic [CRN*DW-1:0]    cr;
  logic [DW-1:0]        sr_in = '0;
  logic [DW-1:0]        sr1_set = '0;
  logic [DW-1:0]        sr2 = '0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic [7:0]           rx_data = '0;
  logic                 rx_pop;
  logic                 swrst;
  logic                 irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_master_csr #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CR_CNT (CRN),
    .SR_CNT (SRN)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .csr_address_i       (addr),
    .csr_write_i         (wr),
    .csr_writedata_i     (wdata),
    .csr_byteenable_i    (be),
    .csr_read_i          (rd),
    .csr_readdata_o      (rdata),
    .csr_readdatavalid_o (rvalid),
    .cr_o                (cr),
    .sr_i                (sr_in),
    .sr1_set_i           (sr1_set),
    .sr2_i               (sr2),
    .tx_data_o           (tx_data),
    .tx_valid_o          (tx_valid),
    .rx_data_i           (rx_data),
    .rx_pop_o            (rx_pop),
    .swrst_o             (swrst),
    .irq_o               (irq)
  );

  // Behavioural model of the register map
  logic [DW-1:0] m_reg [CRN];
  logic [DW-1:0] m_sr1;
  logic [7:0]    m_tx;
  logic          m_irq;
  logic [DW-1:0] e_rdata;
  logic          e_rvalid, e_txv, e_pop, e_sw;

  task automatic chk(input string tag, input logic [CRN*DW-1:0] obs, input logic [CRN*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CRN*DW-1:0] model_cr();
    logic [CRN*DW-1:0] f;
    f = '0;
    for (int i = 0; i < CRN; i++) begin
      if (i == I2C_SR1_CR)                          f[i*DW +: DW] = m_sr1;
      else if (i == I2C_DR_CR || i == I2C_SR2_CR)   f[i*DW +: DW] = '0;
      else                                          f[i*DW +: DW] = m_reg[i];
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CRN; i++) m_reg[i] = '0;
    m_sr1 = '0; m_tx = '0; m_irq = 1'b0;
    e_rdata = '0; e_rvalid = 0; e_txv = 0; e_pop = 0; e_sw = 0;
  endtask

  // Applies one bus cycle to the model using the current engine-side inputs
  task automatic model_step(input logic w, input logic r, input int a,
                            input logic [DW-1:0] wd, input logic [1:0] b,
                            input logic [DW-1:0] s);
    logic [DW-1:0] m;
    logic generic;
    m = {{8{b[1]}}, {8{b[0]}}};
    generic = (a == I2C_CR1_CR || a == I2C_CR2_CR || a == I2C_OAR1_CR ||
               a == I2C_OAR2_CR || a == I2C_CCR_CR || a == I2C_TRISE_CR);
    // read observes the state before this cycle's write
    e_rvalid = r;
    e_pop    = r && (a == I2C_DR_CR);
    e_rdata  = '0;
    if (r) begin
      if (a == I2C_DR_CR)        e_rdata = {8'h00, rx_data};
      else if (a == I2C_SR1_CR)  e_rdata = m_sr1;
      else if (a == I2C_SR2_CR)  e_rdata = sr2;
      else if (a < CRN)          e_rdata = m_reg[a];
      else if (a == CRN)         e_rdata = I2C_VER;
      else if (a == CRN + 1)     e_rdata = sr_in;
    end
    e_txv = 0;
    e_sw  = 0;
    m_reg[I2C_CR1_CR][I2C_CR1_START] = 1'b0;
    m_reg[I2C_CR1_CR][I2C_CR1_STOP]  = 1'b0;
    if (w && a == I2C_CR1_CR && b[1] && wd[15]) begin
      for (int i = 0; i < CRN; i++) m_reg[i] = '0;
      m_sr1 = '0;
      e_sw  = 1;
    end else begin
      if (w && generic) m_reg[a] = (m_reg[a] & ~m) | (wd & m);
      m_reg[I2C_CR1_CR][15] = 1'b0;
      if (w && a == I2C_DR_CR && b[0]) begin
        m_tx  = wd[7:0];
        e_txv = 1;
      end
      if (w && a == I2C_SR1_CR) m_sr1 = m_sr1 & ~(wd & m);
      m_sr1 = m_sr1 | s;
    end
    m_irq = (m_sr1 != 0) && m_reg[I2C_CR1_CR][0];
  endtask

  task automatic bus(input logic w, input logic r, input int a,
                     input logic [DW-1:0] wd, input logic [1:0] b,
                     input logic [DW-1:0] s);
    wr = w; rd = r; addr = AW'(a); wdata = wd; be = b; sr1_set = s;
    model_step(w, r, a, wd, b, s);
    @(posedge clk);
    #1;
    wr = 0; rd = 0; sr1_set = '0;
    chk("cr_o", cr, model_cr());
    chk("readdatavalid", rvalid, e_rvalid);
    if (e_rvalid) chk("readdata", rdata, e_rdata);
    chk("tx_valid", tx_valid, e_txv);
    chk("tx_data", tx_data, m_tx);
    chk("rx_pop", rx_pop, e_pop);
    chk("swrst", swrst, e_sw);
    chk("irq", irq, m_irq);
  endtask

  task automatic idle();
    bus(0, 0, 0, '0, 2'b00, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset cr_o", cr, '0);
    chk("reset readdata", rdata, '0);
    chk("reset readdatavalid", rvalid, 1'b0);
    chk("reset strobes", {tx_valid, rx_pop, swrst, irq}, 4'b0000);
    chk("reset tx_data", tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Read the whole map after reset
    for (int i = 0; i <= CRN + 1; i++) begin
      bus(0, 1, i, '0, 2'b00, '0);
      chk("map read", rdata, (i == CRN) ? 16'h0001 : 16'h0000);
    end
    idle();

    // START/STOP self-clear
    bus(1, 0, I2C_CR1_CR, 16'h0301, 2'b11, '0);
    chk("cr1 written", cr[15:0], 16'h0301);
    idle();
    chk("cr1 self-cleared", cr[15:0], 16'h0001);
    bus(0, 1, I2C_CR1_CR, '0, 2'b00, '0);
    chk("cr1 read", rdata, 16'h0001);

    // Byte-enabled CCR write
    bus(1, 0, I2C_CCR_CR, 16'hABCD, 2'b10, '0);
    chk("ccr upper lane", cr[I2C_CCR_CR*DW +: DW], 16'hAB00);

    // SR1 sticky flags and interrupt
    bus(0, 0, 0, '0, 2'b00, 16'h0081);
    chk("irq rise", irq, 1'b1);
    bus(1, 0, I2C_SR1_CR, 16'h0001, 2'b11, 16'h0001);
    chk("sr1 set wins", cr[I2C_SR1_CR*DW +: DW], 16'h0081);
    bus(1, 0, I2C_SR1_CR, 16'h0081, 2'b11, '0);
    chk("sr1 cleared", cr[I2C_SR1_CR*DW +: DW], 16'h0000);
    chk("irq fall", irq, 1'b0);

    // DR push/pop
    bus(1, 0, I2C_DR_CR, 16'h005A, 2'b11, '0);
    chk("tx byte", tx_data, 8'h5A);
    chk("tx push", tx_valid, 1'b1);
    idle();
    rx_data = 8'hC3;
    bus(0, 1, I2C_DR_CR, '0, 2'b00, '0);
    chk("dr read", rdata, 16'h00C3);
    chk("rx pop", rx_pop, 1'b1);
    idle();

    // Software reset
    bus(1, 0, I2C_CR2_CR, 16'h0010, 2'b11, '0);
    bus(1, 0, I2C_CR1_CR, 16'h8000, 2'b11, '0);
    chk("swrst clears all", cr, '0);
    chk("swrst pulse", swrst, 1'b1);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] wd, s;
      wd = DW'($urandom);
      if ($urandom_range(0, 3) != 0) wd[15] = 1'b0;
      s = ($urandom_range(0, 3) == 0) ? DW'($urandom & $urandom) : '0;
      rx_data = 8'($urandom);
      sr2     = DW'($urandom);
      sr_in   = DW'($urandom);
      bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 15), wd, 2'($urandom_range(0, 3)), s);
    end

    // Asynchronous reset in the middle of a read
    bus(1, 0, I2C_CR1_CR, 16'h0001, 2'b11, 16'h0004);
    wr = 0; rd = 1; addr = AW'(I2C_CR1_CR);
    @(posedge clk);
    #1;
    chk("read before reset", rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("readdatavalid on reset", rvalid, 1'b0);
    chk("cr_o on reset", cr, '0);
    chk("irq on reset", irq, 1'b0);
    rd = 0;
    model_reset();
    #2;
    rst_n = 1'b1;
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
